// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Multiplexed seven-segment scan controller with load-strobed
//               snapshot, anti-ghost blank gap and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
    parameter int DIGITS         = 8,
    parameter int REFRESH_CYCLES = 1000,
    parameter int BLANK_CYCLES   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     en_i,
    input  logic                  load_i,
    input  logic                  lzb_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  scan_tick_o
);

    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [4*DIGITS-1:0]  r_data;
    logic [DIGITS-1:0]    r_dp;
    logic [DIGITS-1:0]    r_en;
    logic [DIGITS-1:0]    r_an;
    logic [6:0]           r_seg;
    logic                 r_dp_out;
    logic                 r_tick;

    logic                 w_blank;
    logic [3:0]           w_nib;
    logic                 w_dp_sel;
    logic                 w_en_sel;
    logic                 w_upper_zero;
    logic                 w_lzb_blank;
    logic                 w_lit;
    logic [DIGITS-1:0]    w_an;
    logic [6:0]           w_seg_dec;

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (r_cnt < c_CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // Select the current digit's fields and whether it and all higher nibbles are zero
    always_comb begin
        w_nib        = 4'h0;
        w_dp_sel     = 1'b0;
        w_en_sel     = 1'b0;
        w_upper_zero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nib        = r_data[4*i +: 4];
                w_dp_sel     = r_dp[i];
                w_en_sel     = r_en[i];
                w_upper_zero = ((r_data >> (4*i)) == '0);
            end
        end
    end

    assign w_lzb_blank = lzb_i && (r_idx != '0) && w_upper_zero;
    assign w_lit       = w_en_sel && !w_lzb_blank && !w_blank;

    always_comb begin
        w_an = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_lit && (r_idx == c_IDX_W'(i))) begin
                w_an[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_seg_dec = 7'b1111111;
        case (w_nib)
            4'h0: w_seg_dec = 7'b0000001;
            4'h1: w_seg_dec = 7'b1001111;
            4'h2: w_seg_dec = 7'b0010010;
            4'h3: w_seg_dec = 7'b0000110;
            4'h4: w_seg_dec = 7'b1001100;
            4'h5: w_seg_dec = 7'b0100100;
            4'h6: w_seg_dec = 7'b0100000;
            4'h7: w_seg_dec = 7'b0001111;
            4'h8: w_seg_dec = 7'b0000000;
            4'h9: w_seg_dec = 7'b0000100;
            4'hA: w_seg_dec = 7'b0001000;
            4'hB: w_seg_dec = 7'b1100000;
            4'hC: w_seg_dec = 7'b0110001;
            4'hD: w_seg_dec = 7'b1000010;
            4'hE: w_seg_dec = 7'b0110000;
            default: w_seg_dec = 7'b0111000;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_dp     <= '0;
            r_en     <= '0;
            r_an     <= '1;
            r_seg    <= 7'b1111111;
            r_dp_out <= 1'b1;
            r_tick   <= 1'b0;
        end else begin
            if (r_cnt == c_CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (load_i) begin
                r_data <= data_i;
                r_dp   <= dp_i;
                r_en   <= en_i;
            end
            r_tick   <= (r_cnt == c_CNT_LAST);
            r_an     <= w_an;
            r_seg    <= w_lit ? w_seg_dec : 7'b1111111;
            r_dp_out <= w_lit ? ~w_dp_sel : 1'b1;
        end
    end

    assign an_o        = r_an;
    assign seg_o       = r_seg;
    assign dp_o        = r_dp_out;
    assign scan_tick_o = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Self-checking bench for seg7_scan_ctrl against a slot-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int D = 4;
    localparam int R = 4;
    localparam int B = 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [15:0]   data_i = '0;
    logic [3:0]    dp_i = '0;
    logic [3:0]    en_i = '0;
    logic          load_i = 1'b0;
    logic          lzb_i = 1'b0;
    logic [6:0]    seg_o;
    logic          dp_o;
    logic [3:0]    an_o;
    logic          scan_tick_o;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: elapsed cycles since reset plus the visible snapshot
    int            n = 0;
    logic [15:0]   m_data = '0;
    logic [3:0]    m_dp = '0;
    logic [3:0]    m_en = '0;
    logic [3:0]    exp_an;
    logic [6:0]    exp_seg;
    logic          exp_dp;
    logic          exp_tick;
    logic          exp_dpv;
    logic [12:0]   exp_vec;
    logic [12:0]   mask;
    logic [6:0]    hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .DIGITS         (D),
        .REFRESH_CYCLES (R),
        .BLANK_CYCLES   (B)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .dp_i        (dp_i),
        .en_i        (en_i),
        .load_i      (load_i),
        .lzb_i       (lzb_i),
        .seg_o       (seg_o),
        .dp_o        (dp_o),
        .an_o        (an_o),
        .scan_tick_o (scan_tick_o)
    );

    // Drive one cycle of inputs, advance the model across the edge, settle after it
    task automatic step(input logic rst, input logic load, input logic [15:0] d,
                        input logic [3:0] dpm, input logic [3:0] en, input logic lzb);
        int cnt, idx;
        logic lit;
        @(negedge clk);
        rst_i  = rst;
        load_i = load;
        data_i = d;
        dp_i   = dpm;
        en_i   = en;
        lzb_i  = lzb;
        @(posedge clk);
        if (rst) begin
            n = 0; m_data = '0; m_dp = '0; m_en = '0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_tick = 1'b0; exp_dpv = 1'b1;
        end else begin
            cnt = n % R;
            idx = (n / R) % D;
            exp_tick = (cnt == R - 1);
            if (cnt < B) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_dpv = 1'b0;
            end else begin
                lit = m_en[idx] && !(lzb && idx > 0 && (m_data >> (4*idx)) == 0);
                exp_dpv = 1'b1;
                if (lit) begin
                    exp_an  = ~(4'(1) << idx);
                    exp_seg = hex_tab[(m_data >> (4*idx)) & 16'hF];
                    exp_dp  = ~m_dp[idx];
                end else begin
                    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
                end
            end
            n++;
            if (load) begin
                m_data = d; m_dp = dpm; m_en = en;
            end
        end
        exp_vec = {exp_an, exp_seg, exp_dp, exp_tick};
        mask    = {4'hF, 7'h7F, exp_dpv, 1'b1};
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 16'h8888, 4'hF, 4'hF, 1'b0);
            tests_run++;
            if (an_o !== 4'b1111 || seg_o !== 7'b1111111 || dp_o !== 1'b1 || scan_tick_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset k=%0d got an=%b seg=%b dp=%b tick=%b exp an=1111 seg=1111111 dp=1 tick=0",
                         k, an_o, seg_o, dp_o, scan_tick_o);
            end
        end
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 16'h1234, 4'hF, 4'hF, 1'b0);
            tests_run++;
            if (an_o !== 4'b1111 || seg_o !== 7'b1111111 || dp_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL dark_after_reset k=%0d got an=%b seg=%b dp=%b exp an=1111 seg=1111111 dp=1",
                         k, an_o, seg_o, dp_o);
            end
        end
    endtask

    task automatic test_scan();
        int lit_d3 = 0;
        step(1'b0, 1'b1, 16'h1234, 4'h0, 4'hF, 1'b0);
        for (int k = 0; k < 24; k++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
            tests_run++;
            if (({an_o, seg_o, dp_o, scan_tick_o} & mask) !== (exp_vec & mask)) begin
                tests_failed++;
                $display("FAIL scan k=%0d got an=%b seg=%b dp=%b tick=%b exp an=%b seg=%b dp=%b tick=%b",
                         k, an_o, seg_o, dp_o, scan_tick_o, exp_an, exp_seg, exp_dp, exp_tick);
            end
            if (an_o === 4'b0111 && seg_o === 7'b1001111) lit_d3++;
        end
        tests_run++;
        if (lit_d3 == 0) begin
            tests_failed++;
            $display("FAIL scan_digit3 got lit_cycles=%0d exp >0", lit_d3);
        end
    endtask

    task automatic test_lzb();
        step(1'b0, 1'b1, 16'h0050, 4'h0, 4'hF, 1'b1);
        for (int k = 0; k < 40; k++) begin
            if (k == 20) step(1'b0, 1'b1, 16'h0000, 4'h0, 4'hF, 1'b1);
            else         step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b1);
            tests_run++;
            if (({an_o, seg_o, dp_o, scan_tick_o} & mask) !== (exp_vec & mask)) begin
                tests_failed++;
                $display("FAIL lzb k=%0d got an=%b seg=%b dp=%b tick=%b exp an=%b seg=%b dp=%b tick=%b",
                         k, an_o, seg_o, dp_o, scan_tick_o, exp_an, exp_seg, exp_dp, exp_tick);
            end
        end
    endtask

    task automatic test_enable_dp();
        step(1'b0, 1'b1, 16'hABCD, 4'b0100, 4'b0101, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
            tests_run++;
            if (({an_o, seg_o, dp_o, scan_tick_o} & mask) !== (exp_vec & mask)) begin
                tests_failed++;
                $display("FAIL enable_dp k=%0d got an=%b seg=%b dp=%b tick=%b exp an=%b seg=%b dp=%b tick=%b",
                         k, an_o, seg_o, dp_o, scan_tick_o, exp_an, exp_seg, exp_dp, exp_tick);
            end
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 16'h1234, 4'h0, 4'hF, 1'b0);
        for (int k = 0; k < 2*R && (n % R) != R - 1; k++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        end
        step(1'b0, 1'b1, 16'hFFFF, 4'h0, 4'hF, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
            tests_run++;
            if (({an_o, seg_o, dp_o, scan_tick_o} & mask) !== (exp_vec & mask)) begin
                tests_failed++;
                $display("FAIL load_at_advance k=%0d got an=%b seg=%b dp=%b tick=%b exp an=%b seg=%b dp=%b tick=%b",
                         k, an_o, seg_o, dp_o, scan_tick_o, exp_an, exp_seg, exp_dp, exp_tick);
            end
        end
    endtask

    task automatic test_mid_reset();
        step(1'b0, 1'b1, 16'h5678, 4'hF, 4'hF, 1'b0);
        for (int k = 0; k < 4*R*D && !((n % R) == 2 && ((n / R) % D) == 2); k++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        end
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        tests_run++;
        if (an_o !== 4'b1111 || seg_o !== 7'b1111111 || dp_o !== 1'b1 || scan_tick_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset got an=%b seg=%b dp=%b tick=%b exp an=1111 seg=1111111 dp=1 tick=0",
                     an_o, seg_o, dp_o, scan_tick_o);
        end
        step(1'b0, 1'b1, 16'h9E0C, 4'h2, 4'hF, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
            tests_run++;
            if (({an_o, seg_o, dp_o, scan_tick_o} & mask) !== (exp_vec & mask)) begin
                tests_failed++;
                $display("FAIL after_reset k=%0d got an=%b seg=%b dp=%b tick=%b exp an=%b seg=%b dp=%b tick=%b",
                         k, an_o, seg_o, dp_o, scan_tick_o, exp_an, exp_seg, exp_dp, exp_tick);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] masks [4] = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000};
        logic        lzb = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) lzb = ~lzb;
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                 16'($urandom) & masks[$urandom_range(0, 3)],
                 4'($urandom), 4'($urandom), lzb);
            tests_run++;
            if (({an_o, seg_o, dp_o, scan_tick_o} & mask) !== (exp_vec & mask)) begin
                tests_failed++;
                $display("FAIL random k=%0d got an=%b seg=%b dp=%b tick=%b exp an=%b seg=%b dp=%b tick=%b",
                         k, an_o, seg_o, dp_o, scan_tick_o, exp_an, exp_seg, exp_dp, exp_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lzb();
        test_enable_dp();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for board-level top wrappers such as the Nexys processor demos. It takes a packed hex word, a decimal-point mask and a digit-enable mask. The word is captured into a snapshot register under a load strobe, so the display never shows a half-updated value. The block time-multiplexes the digits with a configurable refresh period, inserts an anti-ghosting blank gap at each digit change, and supports leading-zero blanking. It drives active-low anodes, segments and decimal point directly.

Parameters:
DIGITS, 8, number of digits / anodes; legal range 1..16.
REFRESH_CYCLES, 1000, clock cycles each digit slot lasts; must be >= 2.
BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off; legal range 0..REFRESH_CYCLES-1.

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous active-high reset
data_i  input  4*DIGITS  packed nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is rightmost
dp_i  input  DIGITS  decimal-point request per digit, 1 = lit
en_i  input  DIGITS  digit enable per digit, 1 = may light
load_i  input  1  when 1 at a clock edge, data_i/dp_i/en_i are captured into the snapshot
lzb_i  input  1  leading-zero blanking mode, level sensitive, not snapshotted
seg_o  output  7  {CA,CB,CC,CD,CE,CF,CG}, active low; bit 6 = CA
dp_o  output  1  decimal point, active low
an_o  output  DIGITS  anodes, active low, at most one bit low
scan_tick_o  output  1  one-cycle pulse on the cycle the digit index advances

Behaviour:
- Reset (rst_i=1 at an edge) values:
  - an_o all 1, seg_o 7'b1111111, dp_o 1, scan_tick_o 0.
  - Prescaler cnt=0, digit index idx=0.
  - Snapshot data/dp/en all 0, so the display is dark until the first load.
  - Reset wins over load_i and every other input on the same edge.
- Prescaler: cnt counts 0..REFRESH_CYCLES-1, then wraps to 0.
  - At an edge where cnt==REFRESH_CYCLES-1: idx advances to idx+1, and from DIGITS-1 wraps to 0.
  - scan_tick_o is registered and is 1 for exactly the cycle after that edge.
- Snapshot: load_i=1 at edge E captures data_i, dp_i and en_i at E.
  - The new value is visible on the outputs from edge E+1.
  - load_i may be held high continuously, giving transparent tracking with that same latency.
  - A load coincident with an idx advance is legal: the new slot shows the new snapshot one cycle later.
- Outputs are fully registered. At edge t+1 the outputs are a function of cnt(t), idx(t), snapshot(t) and lzb_i(t):
  - If cnt(t) < BLANK_CYCLES: an_o all 1 and seg_o all 1.
  - Else, digit i=idx(t) is lit if en[i]=1 and it is not LZB-blanked.
  - Lit: an_o has only bit i low; seg_o = hex decode of nibble i; dp_o = ~dp[i].
  - Not lit: an_o all 1, seg_o all 1, dp_o 1.
- LZB-blanked digit: lzb_i=1, i>0, and nibble i plus every higher nibble are zero. Digit 0 is never LZB-blanked.
- Hex decode table (CA..CG order):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- DIGITS=1: idx stays 0; scan_tick_o still pulses once every REFRESH_CYCLES cycles.
- Reset mid-scan: the next cycle reports the reset values and the scan restarts from digit 0, cnt 0.

Test Plan:
1. DIGITS=4, REFRESH_CYCLES=4, BLANK_CYCLES=1; hold rst_i 3 cycles -> an_o=4'b1111, seg_o=7'b1111111, dp_o=1, scan_tick_o=0 throughout; still dark 20 cycles after release (snapshot en=0).
2. Load data_i=16'h1234, en_i=4'hF, dp_i=0 -> each 4-cycle slot shows 1 cycle of an_o=1111, then 3 cycles of the digit:
   - digit 0: an_o=1110, seg_o=1001100
   - digit 1: an_o=1101, seg_o=0000110
   - digit 2: an_o=1011, seg_o=0010010
   - digit 3: an_o=0111, seg_o=1001111
   - then wraps to digit 0; scan_tick_o pulses every 4 cycles.
3. lzb_i=1, load 16'h0050 -> digits 3,2 keep an_o=1111; digit 1 shows 0100100; digit 0 shows 0000001.
   - Then load 16'h0000 -> only digit 0 is lit, showing 0000001.
4. Load en_i=4'b0101, dp_i=4'b0100, data 16'hABCD -> only digits 0 (d=1000010) and 2 (b=1100000) light; dp_o=0 only during digit 2's lit cycles.
5. Assert load_i on the same edge as an idx advance with new data 16'hFFFF -> the first lit cycle of the new slot shows F=0111000; no cycle shows a mixed old/new value.
6. Assert rst_i for 1 cycle mid-slot of digit 2 -> the following cycle has an_o=1111 and a cleared snapshot; after reload the scan restarts at digit 0 with the first tick 4 cycles after release.
